// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and command tables for the VMA412 panel sequencer.
package lcd_pkg;

  localparam int SCREEN_W   = 64;
  localparam int SCREEN_H   = 32;
  localparam int NUM_PIXELS = SCREEN_W * SCREEN_H;

  localparam logic [7:0] CMD_SLEEP_OUT = 8'h11;
  localparam logic [7:0] CMD_COLMOD    = 8'h3A;
  localparam logic [7:0] CMD_MADCTL    = 8'h36;
  localparam logic [7:0] CMD_DISP_ON   = 8'h29;
  localparam logic [7:0] CMD_CASET     = 8'h2A;
  localparam logic [7:0] CMD_RASET     = 8'h2B;
  localparam logic [7:0] CMD_RAMWR     = 8'h2C;

  localparam int INIT_LEN = 6;
  localparam int WIN_LEN  = 11;

  typedef enum logic [2:0] {
    ST_HW_RESET   = 3'd0,
    ST_HW_WAIT    = 3'd1,
    ST_INIT       = 3'd2,
    ST_SLEEP_WAIT = 3'd3,
    ST_IDLE       = 3'd4,
    ST_WINDOW     = 3'd5,
    ST_PIXELS     = 3'd6
  } lcd_state_e;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } lcd_byte_t;

  function automatic lcd_byte_t init_entry(input logic [3:0] idx);
    lcd_byte_t e;
    case (idx)
      4'd0:    e = '{dc: 1'b0, data: CMD_SLEEP_OUT};
      4'd1:    e = '{dc: 1'b0, data: CMD_COLMOD};
      4'd2:    e = '{dc: 1'b1, data: 8'h55};
      4'd3:    e = '{dc: 1'b0, data: CMD_MADCTL};
      4'd4:    e = '{dc: 1'b1, data: 8'h00};
      4'd5:    e = '{dc: 1'b0, data: CMD_DISP_ON};
      default: e = '{dc: 1'b1, data: 8'h00};
    endcase
    return e;
  endfunction

  // Column window 0..W-1, row window 0..H-1, then memory write.
  function automatic lcd_byte_t window_entry(input logic [3:0] idx);
    lcd_byte_t e;
    case (idx)
      4'd0:    e = '{dc: 1'b0, data: CMD_CASET};
      4'd4:    e = '{dc: 1'b1, data: 8'(SCREEN_W - 1)};
      4'd5:    e = '{dc: 1'b0, data: CMD_RASET};
      4'd9:    e = '{dc: 1'b1, data: 8'(SCREEN_H - 1)};
      4'd10:   e = '{dc: 1'b0, data: CMD_RAMWR};
      default: e = '{dc: 1'b1, data: 8'h00};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// One-byte 8080 write engine: wrx low for CLK_DIV cycles, then high for CLK_DIV cycles.
// A new start is accepted in the final high cycle so bytes can run back-to-back.
module lcd_bus_writer #(
  parameter int CLK_DIV = 1
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       dc_i,
  output logic       done_o,
  output logic       wrx_o,
  output logic [7:0] data_o,
  output logic       dcx_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic          active_q, active_d;
  logic          high_q, high_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrx_q, wrx_d;
  logic [7:0]    data_q, data_d;
  logic          dcx_q, dcx_d;

  assign done_o = active_q && high_q && (cnt_q == '0);

  always_comb begin
    active_d = active_q;
    high_d   = high_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    dcx_d    = dcx_q;
    if (start_i && (!active_q || done_o)) begin
      active_d = 1'b1;
      high_d   = 1'b0;
      cnt_d    = DIV_LAST;
      data_d   = byte_i;
      dcx_d    = dc_i;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else if (!high_q) begin
        high_d = 1'b1;
        cnt_d  = DIV_LAST;
      end else begin
        active_d = 1'b0;
      end
    end
    // Registered strobe keeps wrx glitch-free at the pin.
    wrx_d = !(active_d && !high_d);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      active_q <= 1'b0;
      high_q   <= 1'b1;
      cnt_q    <= '0;
      wrx_q    <= 1'b1;
      data_q   <= 8'h00;
      dcx_q    <= 1'b1;
    end else begin
      active_q <= active_d;
      high_q   <= high_d;
      cnt_q    <= cnt_d;
      wrx_q    <= wrx_d;
      data_q   <= data_d;
      dcx_q    <= dcx_d;
    end
  end

  assign wrx_o  = wrx_q;
  assign data_o = data_q;
  assign dcx_o  = dcx_q;

endmodule

// File: rtl/lcd_frame_sequencer.sv
// VMA412 panel sequencer: hardware reset, init table, then one RGB565 frame per request.
//
// state         | meaning
// HW_RESET      | resx held low for RESET_CYCLES
// HW_WAIT       | resx high, settle for RESET_CYCLES
// INIT          | sending init table bytes
// SLEEP_WAIT    | SLEEP_DELAY cycles after sleep-out
// IDLE          | ready, frame_start accepted here only
// WINDOW        | sending column/row window and memory-write command
// PIXELS        | sending 2048 pixels, high colour byte first
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int          CLK_DIV      = 1,
  parameter int          RESET_CYCLES = 1000,
  parameter int          SLEEP_DELAY  = 6000000,
  parameter logic [15:0] FG_COLOR     = 16'hFFFF,
  parameter logic [15:0] BG_COLOR     = 16'h0000
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic [0:2047] screen_i,
  input  logic          frame_start_i,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic [7:0]    data_o,
  output logic          csx_o,
  output logic          resx_o,
  output logic          dcx_o,
  output logic          wrx_o,
  output logic          rdx_o
);

  localparam int DLY_MAX = (RESET_CYCLES > SLEEP_DELAY) ? RESET_CYCLES : SLEEP_DELAY;
  localparam int DW      = $clog2(DLY_MAX + 1);
  localparam logic [DW-1:0] RST_LAST   = DW'(RESET_CYCLES - 1);
  localparam logic [DW-1:0] SLEEP_LAST = DW'(SLEEP_DELAY - 1);
  localparam logic [10:0]   PIX_LAST   = 11'(NUM_PIXELS - 1);

  lcd_state_e    state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [3:0]    idx_q, idx_d;
  logic [10:0]   pix_q, pix_d;
  logic          phase_q, phase_d;
  logic          frame_done_q, frame_done_d;

  logic          wr_start;
  lcd_byte_t     wr_byte;
  logic          wr_done;

  logic [10:0]   nxt_pix;
  logic          nxt_phase;
  logic [15:0]   nxt_color;
  logic [15:0]   first_color;

  always_comb begin
    state_d      = state_q;
    dly_d        = dly_q;
    idx_d        = idx_q;
    pix_d        = pix_q;
    phase_d      = phase_q;
    frame_done_d = 1'b0;
    wr_start     = 1'b0;
    wr_byte      = '{dc: 1'b1, data: 8'h00};

    // phase_q=1 means the low byte of pix_q is on the bus.
    nxt_phase   = !phase_q;
    nxt_pix     = phase_q ? (pix_q + 11'd1) : pix_q;
    nxt_color   = screen_i[nxt_pix] ? FG_COLOR : BG_COLOR;
    first_color = screen_i[0] ? FG_COLOR : BG_COLOR;

    case (state_q)
      ST_HW_RESET: begin
        if (dly_q == '0) begin
          state_d = ST_HW_WAIT;
          dly_d   = RST_LAST;
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end
      ST_HW_WAIT: begin
        if (dly_q == '0) begin
          wr_start = 1'b1;
          wr_byte  = init_entry(4'd0);
          idx_d    = 4'd0;
          state_d  = ST_INIT;
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end
      ST_INIT: begin
        if (wr_done) begin
          if (idx_q == 4'd0) begin
            state_d = ST_SLEEP_WAIT;
            dly_d   = SLEEP_LAST;
            idx_d   = 4'd1;
          end else if (idx_q == 4'(INIT_LEN - 1)) begin
            state_d = ST_IDLE;
          end else begin
            wr_start = 1'b1;
            wr_byte  = init_entry(idx_q + 4'd1);
            idx_d    = idx_q + 4'd1;
          end
        end
      end
      ST_SLEEP_WAIT: begin
        if (dly_q == '0) begin
          wr_start = 1'b1;
          wr_byte  = init_entry(idx_q);
          state_d  = ST_INIT;
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end
      ST_IDLE: begin
        if (frame_start_i) begin
          wr_start = 1'b1;
          wr_byte  = window_entry(4'd0);
          idx_d    = 4'd0;
          state_d  = ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        if (wr_done) begin
          if (idx_q == 4'(WIN_LEN - 1)) begin
            wr_start = 1'b1;
            wr_byte  = '{dc: 1'b1, data: first_color[15:8]};
            pix_d    = 11'd0;
            phase_d  = 1'b0;
            state_d  = ST_PIXELS;
          end else begin
            wr_start = 1'b1;
            wr_byte  = window_entry(idx_q + 4'd1);
            idx_d    = idx_q + 4'd1;
          end
        end
      end
      ST_PIXELS: begin
        if (wr_done) begin
          if ((pix_q == PIX_LAST) && phase_q) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end else begin
            wr_start = 1'b1;
            wr_byte  = '{dc: 1'b1, data: nxt_phase ? nxt_color[7:0] : nxt_color[15:8]};
            pix_d    = nxt_pix;
            phase_d  = nxt_phase;
          end
        end
      end
      default: state_d = ST_HW_RESET;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_HW_RESET;
      dly_q        <= RST_LAST;
      idx_q        <= 4'd0;
      pix_q        <= 11'd0;
      phase_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      idx_q        <= idx_d;
      pix_q        <= pix_d;
      phase_q      <= phase_d;
      frame_done_q <= frame_done_d;
    end
  end

  lcd_bus_writer #(
    .CLK_DIV(CLK_DIV)
  ) u_writer (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .start_i(wr_start),
    .byte_i (wr_byte.data),
    .dc_i   (wr_byte.dc),
    .done_o (wr_done),
    .wrx_o  (wrx_o),
    .data_o (data_o),
    .dcx_o  (dcx_o)
  );

  assign busy_o       = (state_q != ST_IDLE);
  assign csx_o        = (state_q == ST_HW_RESET) || (state_q == ST_HW_WAIT) || (state_q == ST_IDLE);
  assign resx_o       = (state_q != ST_HW_RESET);
  assign rdx_o        = 1'b1;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Bench for lcd_frame_sequencer: two instances (CLK_DIV=1 and 3) checked against a byte-stream model.
module tb_lcd_frame_sequencer;

  localparam int RC = 4;
  localparam int SD = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [2];
  logic          fs    [2];
  logic [0:2047] scr   [2];
  logic          busy  [2];
  logic          fd    [2];
  logic [7:0]    data  [2];
  logic          csx   [2];
  logic          resx  [2];
  logic          dcx   [2];
  logic          wrx   [2];
  logic          rdx   [2];

  lcd_frame_sequencer #(
    .CLK_DIV(1), .RESET_CYCLES(RC), .SLEEP_DELAY(SD),
    .FG_COLOR(16'hF800), .BG_COLOR(16'h0000)
  ) dut0 (
    .clock_i(clk), .reset_i(rst_n[0]), .screen_i(scr[0]), .frame_start_i(fs[0]),
    .busy_o(busy[0]), .frame_done_o(fd[0]), .data_o(data[0]), .csx_o(csx[0]),
    .resx_o(resx[0]), .dcx_o(dcx[0]), .wrx_o(wrx[0]), .rdx_o(rdx[0])
  );

  lcd_frame_sequencer #(
    .CLK_DIV(3), .RESET_CYCLES(RC), .SLEEP_DELAY(SD),
    .FG_COLOR(16'h07E0), .BG_COLOR(16'h001F)
  ) dut1 (
    .clock_i(clk), .reset_i(rst_n[1]), .screen_i(scr[1]), .frame_start_i(fs[1]),
    .busy_o(busy[1]), .frame_done_o(fd[1]), .data_o(data[1]), .csx_o(csx[1]),
    .resx_o(resx[1]), .dcx_o(dcx[1]), .wrx_o(wrx[1]), .rdx_o(rdx[1])
  );

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Bus monitor: captures every byte at its wrx fall and tallies timing/hold violations.
  int         cyc = 0;
  logic [8:0] cap      [2][$];
  int         fall_cyc [2][$];
  logic       prev_wrx [2];
  logic [8:0] cur      [2];
  int         low_run  [2];
  int         hold_left[2];
  int         low_bad  [2];
  int         high_bad [2];
  int         hold_bad [2];
  int         csx_bad  [2];
  int         fd_cnt   [2];
  int         fd_cyc   [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      prev_wrx[k] = 1'b1; cur[k] = '0; low_run[k] = 0; hold_left[k] = 0;
      low_bad[k] = 0; high_bad[k] = 0; hold_bad[k] = 0; csx_bad[k] = 0;
      fd_cnt[k] = 0; fd_cyc[k] = -1;
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) begin
        prev_wrx[k] = 1'b1; hold_left[k] = 0; low_run[k] = 0;
      end else begin
        if (fd[k]) begin fd_cnt[k]++; fd_cyc[k] = cyc; end
        if (prev_wrx[k] && !wrx[k]) begin
          if (hold_left[k] != 0) high_bad[k]++;
          if (csx[k] !== 1'b0) csx_bad[k]++;
          cur[k] = {dcx[k], data[k]};
          cap[k].push_back(cur[k]);
          fall_cyc[k].push_back(cyc);
          low_run[k] = 1;
        end else if (!wrx[k]) begin
          low_run[k]++;
          if ({dcx[k], data[k]} !== cur[k]) hold_bad[k]++;
        end else if (!prev_wrx[k]) begin
          if (low_run[k] != div_of(k)) low_bad[k]++;
          if ({dcx[k], data[k]} !== cur[k]) hold_bad[k]++;
          hold_left[k] = div_of(k) - 1;
        end else if (hold_left[k] > 0) begin
          if ({dcx[k], data[k]} !== cur[k]) hold_bad[k]++;
          hold_left[k]--;
        end
        prev_wrx[k] = wrx[k];
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int fall_at(input int k, input int i);
    return (fall_cyc[k].size() > i) ? fall_cyc[k][i] : -100000;
  endfunction

  task automatic clear_cap(input int k);
    cap[k].delete();
    fall_cyc[k].delete();
  endtask

  task automatic build_init();
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h3A});
    exp_q.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b0, 8'h36});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b0, 8'h29});
  endtask

  task automatic build_frame(input logic [0:2047] s, input logic [15:0] fg, input logic [15:0] bg);
    logic [15:0] c;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'h3F});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'h1F});
    exp_q.push_back({1'b0, 8'h2C});
    for (int i = 0; i < 2048; i++) begin
      c = s[i] ? fg : bg;
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
  endtask

  task automatic cmp_stream(input int k, input string tag);
    int bad = 0;
    int first = -1;
    int n;
    chk({tag, "_len"}, cap[k].size(), exp_q.size());
    n = (cap[k].size() < exp_q.size()) ? cap[k].size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (cap[k][i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0)
      $display("stream %s first difference at byte %0d: got %0h want %0h",
               tag, first, cap[k][first], exp_q[first]);
    chk({tag, "_bad_bytes"}, bad, 0);
  endtask

  task automatic wait_idle(input int k, input int limit, input string tag, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      if (!busy[k]) begin at = cyc; break; end
      tick();
    end
    chk(tag, int'(at >= 0), 1);
  endtask

  task automatic do_frame0(input string tag);
    int acc;
    int base;
    int ok;
    clear_cap(0);
    base = fd_cnt[0];
    fs[0] = 1'b1;
    acc = cyc;
    tick();
    fs[0] = 1'b0;
    chk({tag, "_busy_after_accept"}, int'(busy[0]), 1);
    ok = 0;
    for (int n = 0; n < 9000; n++) begin
      if (fd_cnt[0] > base) begin ok = 1; break; end
      fs[0] = (n == 3000);
      tick();
    end
    fs[0] = 1'b0;
    chk({tag, "_done_seen"}, ok, 1);
    chk({tag, "_first_fall_lat"}, fall_at(0, 0) - acc, 1);
    chk({tag, "_done_lat"}, fd_cyc[0] - acc, 4107 * 2 + 1);
    repeat (20) tick();
    chk({tag, "_done_count"}, fd_cnt[0], base + 1);
    chk({tag, "_busy_end"}, int'(busy[0]), 0);
    chk({tag, "_csx_end"}, int'(csx[0]), 1);
    build_frame(scr[0], 16'hF800, 16'h0000);
    cmp_stream(0, tag);
  endtask

  int lowcnt, r_rise, bf0, bf1, acc1, ok, fd_before;

  initial begin
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    fs[0] = 1'b0; fs[1] = 1'b0;
    scr[0] = '0; scr[1] = '0;
    repeat (3) tick();

    chk("rst_resx", int'(resx[0]), 0);
    chk("rst_csx",  int'(csx[0]), 1);
    chk("rst_wrx",  int'(wrx[0]), 1);
    chk("rst_rdx",  int'(rdx[0]), 1);
    chk("rst_dcx",  int'(dcx[0]), 1);
    chk("rst_data", int'(data[0]), 0);
    chk("rst_busy", int'(busy[0]), 1);
    chk("rst_done", int'(fd[0]), 0);

    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    lowcnt = 0; r_rise = -1;
    for (int n = 0; n < 100; n++) begin
      if (resx[0]) begin r_rise = cyc; break; end
      lowcnt++;
      tick();
    end
    chk("resx_low_cycles", lowcnt, RC);

    ok = 0;
    for (int n = 0; n < 200; n++) begin
      if (cap[0].size() >= 1) begin ok = 1; break; end
      tick();
    end
    chk("first_init_byte_seen", ok, 1);
    repeat (2) tick();
    fs[0] = 1'b1; fs[1] = 1'b1;
    tick();
    fs[0] = 1'b0; fs[1] = 1'b0;

    wait_idle(0, 300, "init0_idle", bf0);
    wait_idle(1, 500, "init1_idle", bf1);
    chk("first_fall_after_resx", fall_at(0, 0) - r_rise, RC);
    chk("sleep_gap", fall_at(0, 1) - fall_at(0, 0), 2 + SD);
    chk("init_back_to_back", fall_at(0, 2) - fall_at(0, 1), 2);
    chk("busy_fall_after_init", bf0 - fall_at(0, 5), 2);
    chk("sleep_gap_div3", fall_at(1, 1) - fall_at(1, 0), 6 + SD);
    build_init();
    cmp_stream(0, "init0");
    cmp_stream(1, "init1");
    repeat (10) tick();
    chk("no_frame_from_init_req0", fd_cnt[0], 0);
    chk("no_frame_from_init_req1", fd_cnt[1], 0);
    chk("no_bytes_after_init0", cap[0].size(), 6);
    chk("csx_idle", int'(csx[0]), 1);
    clear_cap(0); clear_cap(1);

    for (int i = 0; i < 2048; i++) scr[1][i] = 1'($urandom_range(0, 1));
    fs[1] = 1'b1;
    acc1 = cyc;
    tick();
    fs[1] = 1'b0;

    scr[0] = '0;
    do_frame0("frame_zero");
    scr[0] = '0;
    scr[0][0] = 1'b1;
    do_frame0("frame_bit0");
    for (int i = 0; i < 2048; i++) scr[0][i] = 1'($urandom_range(0, 1));
    do_frame0("frame_rand");

    ok = 0;
    for (int n = 0; n < 30000; n++) begin
      if (fd_cnt[1] >= 1) begin ok = 1; break; end
      tick();
    end
    chk("div3_done_seen", ok, 1);
    chk("div3_first_fall_lat", fall_at(1, 0) - acc1, 1);
    chk("div3_done_lat", fd_cyc[1] - acc1, 4107 * 6 + 1);
    chk("div3_done_count", fd_cnt[1], 1);
    build_frame(scr[1], 16'h07E0, 16'h001F);
    cmp_stream(1, "frame_div3");

    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wrx_low_len_dut%0d", k), low_bad[k], 0);
      chk($sformatf("wrx_high_len_dut%0d", k), high_bad[k], 0);
      chk($sformatf("data_hold_dut%0d", k), hold_bad[k], 0);
      chk($sformatf("csx_during_write_dut%0d", k), csx_bad[k], 0);
    end

    clear_cap(0);
    for (int i = 0; i < 2048; i++) scr[0][i] = 1'($urandom_range(0, 1));
    fs[0] = 1'b1;
    tick();
    fs[0] = 1'b0;
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      if (cap[0].size() >= 300) begin ok = 1; break; end
      tick();
    end
    chk("reached_pixels", ok, 1);
    fd_before = fd_cnt[0];
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("async_rst_outputs",
        int'({resx[0], csx[0], wrx[0], rdx[0], dcx[0], data[0], busy[0], fd[0]}),
        int'({1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0}));
    repeat (3) tick();
    clear_cap(0);
    rst_n[0] = 1'b1;
    chk("restart_resx_low", int'(resx[0]), 0);
    wait_idle(0, 300, "reinit_idle", bf0);
    build_init();
    cmp_stream(0, "reinit");
    repeat (10) tick();
    chk("no_done_after_abort", fd_cnt[0], fd_before);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_frame_sequencer.md
Name: lcd_frame_sequencer

Overview:
Sequences the VMA412 TFT panel over its 8080-style 8-bit write bus. After reset it pulses the panel's hardware reset and sends a fixed init command table. Afterwards, on each request it pushes one 64x32 monochrome framebuffer to the panel as RGB565. The block sits between the framebuffer owner and the panel pins and is the only driver of the bus.

Parameters:
CLK_DIV, 1, clock cycles per wrx phase (low phase and high phase each last CLK_DIV cycles); must be >= 1.
RESET_CYCLES, 1000, cycles resx is held low, and also cycles waited after resx rises.
SLEEP_DELAY, 6000000, wait cycles after the sleep-out command (0x11).
FG_COLOR, 16'hFFFF, RGB565 colour for a pixel bit of 1.
BG_COLOR, 16'h0000, RGB565 colour for a pixel bit of 0.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
screen  in  [0:2047]  framebuffer; bit y*64+x is pixel (x,y); sampled live, so the owner must hold it stable while busy=1.
frame_start  in  1  one-cycle request to push one frame.
busy  out  1  high during reset/init and during a frame push.
frame_done  out  1  one-cycle pulse when a frame push completes.
data  out  8  panel data bus (write-only).
csx  out  1  chip select, active low.
resx  out  1  panel reset, active low.
dcx  out  1  0 = command byte, 1 = parameter/pixel byte.
wrx  out  1  write strobe; the panel latches on the rising edge.
rdx  out  1  read strobe; held at 1.

Behaviour:
- Reset values, applied asynchronously while reset=0: resx=0, csx=1, wrx=1, rdx=1, dcx=1, data=8'h00, busy=1, frame_done=0, state=HW_RESET.
- States: HW_RESET -> HW_WAIT -> INIT -> SLEEP_WAIT -> INIT -> IDLE -> WINDOW -> PIXELS -> IDLE.
- HW_RESET: hold resx=0 for RESET_CYCLES cycles. HW_WAIT: drive resx=1, wait RESET_CYCLES cycles.
- INIT sends, in order:
  - 0x11 (cmd), then SLEEP_WAIT for SLEEP_DELAY cycles.
  - 0x3A (cmd), 0x55 (param).
  - 0x36 (cmd), 0x00 (param).
  - 0x29 (cmd).
  - Then enter IDLE and drop busy to 0.
- Byte write timing:
  - data and dcx are set in the same cycle wrx falls.
  - wrx stays low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - data and dcx are held unchanged through the rising edge and the whole high phase.
  - One byte takes 2*CLK_DIV cycles; consecutive bytes are back-to-back.
- csx=0 throughout INIT/SLEEP_WAIT/WINDOW/PIXELS; csx=1 in HW_RESET, HW_WAIT and IDLE.
- IDLE: frame_start=1 -> next cycle busy=1, enter WINDOW.
- frame_start is ignored (not queued) in every other state, including during init.
- WINDOW sends:
  - 0x2A (cmd), then params 0x00, 0x00, 0x00, 0x3F.
  - 0x2B (cmd), then params 0x00, 0x00, 0x00, 0x1F.
  - 0x2C (cmd).
  - Total: 11 bytes.
- PIXELS:
  - Pixel index i runs 0..2047; screen[i]=1 selects FG_COLOR, else BG_COLOR.
  - Colour high byte is sent first; dcx=1.
  - Total: 4096 bytes.
- Completion: in the cycle after the final wrx high phase ends, frame_done=1 for one cycle, busy=0, state=IDLE, csx=1.
- Frame latency: first wrx fall is the cycle after acceptance; frame_done comes 4107*2*CLK_DIV+1 cycles after acceptance.
- Counters: pixel counter is 11 bits, byte-phase is 1 bit, delay counter is wide enough for max(RESET_CYCLES, SLEEP_DELAY). No wrap is permitted beyond the terminal counts.
- Reset mid-operation: immediate return to reset values; the full sequence restarts from HW_RESET and the partial frame is discarded.

Decomposition:
- Shared package lcd_pkg holds:
  - command opcodes 0x11, 0x3A, 0x36, 0x29, 0x2A, 0x2B, 0x2C;
  - SCREEN_W=64, SCREEN_H=32;
  - the state enum.
- Sub-module lcd_bus_writer: a one-byte 8080 write engine.
  - Inputs: start, byte, dc. Outputs: done pulse, wrx/data/dcx.
  - Timing parameterised by CLK_DIV.
  - The top-level FSM feeds it bytes from the init/window tables and the pixel expander.

Test Plan:
- Reset release with RESET_CYCLES=4, SLEEP_DELAY=10, CLK_DIV=1 -> resx low 4 cycles, then high 4 cycles. Bytes are 11/dc0, then a 10-cycle gap, then 3A/dc0, 55/dc1, 36/dc0, 00/dc1, 29/dc0. busy falls after the final byte.
- frame_start with screen all 0, BG_COLOR=0000 -> the 11 window bytes appear exactly, then 4096 bytes of 0x00. A single frame_done pulse occurs 8215 cycles after acceptance.
- screen bit 0 set only, FG_COLOR=F800 -> first pixel bytes are F8, 00; all 4094 remaining bytes are 00.
- frame_start pulsed during init and again mid-frame -> no extra frame is produced; frame_done count is 1.
- CLK_DIV=3 -> wrx low 3 cycles, high 3 cycles. data and dcx are constant from the wrx fall through the end of the high phase.
- reset asserted mid-PIXELS -> all outputs take reset values in the same cycle (asynchronously). After release, the sequence restarts with resx low and no frame_done is produced.
